br_issue_sched: RTL
===================

# br_issue_sched

Age-ordered issue scheduler for the branch functional unit. Holds up to DEPTH dispatched branch/jump micro-ops and tracks source-operand readiness through CDB wakeups. Each cycle it offers the oldest fully-ready entry to the branch FU over a valid/ready handshake. It sits between rename/dispatch and the branch FU inside the backend branch cluster and drops all contents on a mispredict flush.

## Interface
- DEPTH, 8: entry count, ≥2
- PRF_IDX_W, 6: physical register tag width
- NUM_CDB, 2: number of CDB broadcast ports
- PAYLOAD_W, 64: opaque micro-op payload (rob id, pc, imm, funct, prediction) passed through unchanged
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  mispredict/redirect flush; clears all entries
- dispatch_valid  in  1  dispatch offers a micro-op
- dispatch_ready  out  1  entry available (occupancy < DEPTH)
- dispatch_rs1_tag / dispatch_rs2_tag  in  PRF_IDX_W each  source tags
- dispatch_rs1_rdy / dispatch_rs2_rdy  in  1 each  source already available at rename
- dispatch_payload  in  PAYLOAD_W  payload
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*PRF_IDX_W  broadcast tags; port i at bits [i*PRF_IDX_W +: PRF_IDX_W]
- issue_valid  out  1  an entry is offered to the FU
- issue_ready  in  1  FU accepts
- issue_rs1_tag / issue_rs2_tag  out  PRF_IDX_W each  tags for PRF read
- issue_payload  out  PAYLOAD_W  payload of offered entry
- occupancy  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Storage: collapsing queue. Slot 0 holds the oldest entry. Valid entries are always contiguous from slot 0, and occupancy equals the valid count.
- Dispatch: dispatch_valid && dispatch_ready writes slot `occupancy − (issue fire ? 1 : 0)`, i.e. the tail after this cycle's collapse.
- Dispatch wakeup bypass: the stored rdy bit for each source is dispatch_rsX_rdy OR (any cdb_valid[i] with cdb_tag[i] == dispatch_rsX_tag) in the same cycle.
- Wakeup: each valid entry sets rs1_rdy / rs2_rdy when any valid CDB port matches its tag. Ready bits never clear while the entry lives.
- Select: the lowest-index valid entry with both rdy bits set in registered state. issue_valid = such an entry exists && !flush. The issue_* outputs come from that slot; they are don't-care when issue_valid=0.
- Issue fire = issue_valid && issue_ready. The selected slot is removed and all higher slots shift down one position in the same write.
- Shifted entries also apply this cycle's CDB wakeups, so no wakeup is lost during collapse.
- Flush: all valid bits clear next cycle. Dispatch and issue in the flush cycle are ignored (issue_valid forced 0). Flush has priority over everything except rst.
- rst has priority over flush. Reset values: valid bits 0, occupancy=0, dispatch_ready=1, issue_valid=0.
- Arithmetic: occupancy next = occupancy + dispatch_fire − issue_fire, which stays within 0..DEPTH.

## Timing
- Dispatch at cycle t → earliest issue_valid at t+1 (both sources ready at dispatch).
- CDB wakeup at cycle t → earliest issue at t+1. There is no same-cycle wakeup-to-select path.
- dispatch_ready depends only on registered occupancy. When full, no dispatch is accepted even if an issue fires that cycle.
- Backpressure: with issue_ready=0, the offered entry stays selected and outputs are stable unless an older entry becomes ready. An older ready entry is preferred next cycle.
- Simultaneous dispatch + issue with occupancy=k: new entry lands in slot k−1, and occupancy stays k.
- Reset or flush asserted mid-handshake: the offer is withdrawn in that same cycle, with no partial issue.

## Configuration
- BR_ISSUE_SCHED_PERF_EN defined: adds 32-bit saturating-free wraparound counters, read hierarchically by the testbench performance monitor and reset by rst only (not flush):
  - perf_issue_cnt: issue fires
  - perf_stall_cnt: cycles with issue_valid && !issue_ready
  - perf_full_cnt: cycles with occupancy == DEPTH
- Undefined: the counters and their logic are absent, with no port change.

## Test plan
- Reset, then dispatch one op with both rdy=1 at cycle 1 and issue_ready=1 → issue_valid=1 at cycle 2 with matching payload; occupancy 1→0 at cycle 3.
- Dispatch A (rs1 tag 5 not ready) then B (ready) → B issues first. CDB tag 5 at cycle t → A issues at t+1.
- Dispatch with rs2 tag 9 while the CDB broadcasts tag 9 in the same cycle → entry stored ready and issues the next cycle.
- Fill 8 entries with issue_ready=0 → dispatch_ready=0; assert issue_ready with dispatch_valid held → one issue and no dispatch that cycle; occupancy 8→7; dispatch is accepted the next cycle.
- Occupancy 4, issue of slot 1 and dispatch together → occupancy stays 4, order preserved as slots 0, 2, 3, new.
- Flush with occupancy 5 and issue_ready=1 → issue_valid=0 that cycle, occupancy=0 next cycle. With PERF_EN, perf_issue_cnt is unchanged by the flush.

Source files
------------

// File: rtl/br_issue_sched.sv
// br_issue_sched -- age-ordered issue scheduler for the branch FU.
//
// Collapsing queue of DEPTH entries; slot 0 is always the oldest and valid
// slots are contiguous from 0, so validity is derived from occupancy.
// Each cycle the lowest-index entry with both sources ready (registered
// state only) is offered to the FU. On an issue fire the higher slots shift
// down one position. Shifted entries pick up this cycle's CDB wakeups on the
// way. A flush drops everything.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               mispredict flush, clears all entries
//   dispatch_*          valid/ready dispatch of a micro-op (tags, rdy, payload)
//   cdb_valid/cdb_tag   NUM_CDB wakeup broadcast ports
//   issue_*             valid/ready offer of the selected entry to the FU
//   occupancy           number of valid entries
//
// Optional build macro BR_ISSUE_SCHED_PERF_EN adds the internal counters
// perf_issue_cnt, perf_stall_cnt and perf_full_cnt (no port change).
module br_issue_sched #(
  parameter int DEPTH     = 8,
  parameter int PRF_IDX_W = 6,
  parameter int NUM_CDB   = 2,
  parameter int PAYLOAD_W = 64,
  localparam int OCC_W    = $clog2(DEPTH + 1),
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [PRF_IDX_W-1:0]         dispatch_rs1_tag,
  input  logic [PRF_IDX_W-1:0]         dispatch_rs2_tag,
  input  logic                         dispatch_rs1_rdy,
  input  logic                         dispatch_rs2_rdy,
  input  logic [PAYLOAD_W-1:0]         dispatch_payload,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*PRF_IDX_W-1:0] cdb_tag,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [PRF_IDX_W-1:0]         issue_rs1_tag,
  output logic [PRF_IDX_W-1:0]         issue_rs2_tag,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [OCC_W-1:0]             occupancy
);

  typedef struct packed {
    logic [PRF_IDX_W-1:0] rs1_tag;
    logic [PRF_IDX_W-1:0] rs2_tag;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            new_ent;
  logic [DEPTH-1:0]  rdy_vec;
  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic              issue_fire;
  logic              dispatch_fire;
  logic [OCC_W-1:0]  tail;

  function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++)
      if (cdb_valid[p] && cdb_tag[p*PRF_IDX_W +: PRF_IDX_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Select: lowest-index fully ready entry, from registered state only.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Offer is withdrawn combinationally on flush or reset.
  assign issue_valid    = sel_any && !flush && !rst;
  assign issue_fire     = issue_valid && issue_ready;
  assign issue_rs1_tag  = ent_q[sel_idx].rs1_tag;
  assign issue_rs2_tag  = ent_q[sel_idx].rs2_tag;
  assign issue_payload  = ent_q[sel_idx].payload;

  // dispatch_ready uses registered occupancy only: full stays full even if an
  // issue fires this cycle.
  assign dispatch_ready = (occupancy < OCC_W'(DEPTH));
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign tail           = occupancy - OCC_W'(issue_fire);

  // New entry with same-cycle CDB bypass.
  always_comb begin
    new_ent.rs1_tag = dispatch_rs1_tag;
    new_ent.rs2_tag = dispatch_rs2_tag;
    new_ent.rs1_rdy = dispatch_rs1_rdy | cdb_hit(dispatch_rs1_tag);
    new_ent.rs2_rdy = dispatch_rs2_rdy | cdb_hit(dispatch_rs2_tag);
    new_ent.payload = dispatch_payload;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    entry_t src;
    entry_t wk;

    assign rdy_vec[i] = (OCC_W'(i) < occupancy) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;

    // Slots at or above the issued one take their upper neighbour.
    if (i < DEPTH - 1) begin : g_sh
      assign src = (issue_fire && sel_idx <= IDX_W'(i)) ? ent_q[i+1] : ent_q[i];
    end else begin : g_top
      assign src = ent_q[i];
    end

    // Wakeup applied after the shift so a collapsing entry keeps it.
    always_comb begin
      wk         = src;
      wk.rs1_rdy = src.rs1_rdy | cdb_hit(src.rs1_tag);
      wk.rs2_rdy = src.rs2_rdy | cdb_hit(src.rs2_tag);
    end

    assign ent_d[i] = (dispatch_fire && tail == OCC_W'(i)) ? new_ent : wk;
  end

  // Payload storage needs no reset: validity lives in occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

  always_ff @(posedge clk) begin
    if (rst)        occupancy <= '0;
    else if (flush) occupancy <= '0;
    else            occupancy <= occupancy + OCC_W'(dispatch_fire) - OCC_W'(issue_fire);
  end

`ifdef BR_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_full_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue_fire)                  perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (issue_valid && !issue_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (occupancy == OCC_W'(DEPTH))  perf_full_cnt  <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule
